// File: rtl/interrupt_arbiter_pkg.sv
// Shared types and constants for the 6502 interrupt arbiter.
package int_arb_pkg;

    typedef enum logic [1:0] {
        KIND_RESET = 2'd0,
        KIND_NMI   = 2'd1,
        KIND_IRQ   = 2'd2
    } kind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SEQ   = 2'd2
    } state_t;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    function automatic logic [15:0] vec_of(input kind_t k);
        case (k)
            KIND_NMI: return VEC_NMI;
            KIND_IRQ: return VEC_IRQ;
            default:  return VEC_RST;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_arbiter_if.sv
// CPU-sequencer / peripheral side signals of the interrupt arbiter.
interface interrupt_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 3
);
    logic               clk_ph1;
    logic               clk_ph2;
    logic               nmi;
    logic [NUM_SRC-1:0] irq_src;
    logic [NUM_SRC-1:0] src_en;
    logic [NUM_SRC-1:0] src_edge;
    logic               irq_mask;
    logic               poll;
    logic               brk;
    logic               int_ack;
    logic               vec_fetch;
    logic               irq_out;
    logic               nmi_out;
    logic               int_out;
    logic [15:0]        int_vec;
    logic [SRC_W-1:0]   int_src;
    logic [NUM_SRC-1:0] src_pending;

    modport master (
        output clk_ph1, clk_ph2, nmi, irq_src, src_en, src_edge,
               irq_mask, poll, brk, int_ack, vec_fetch,
        input  irq_out, nmi_out, int_out, int_vec, int_src, src_pending
    );

    modport slave (
        input  clk_ph1, clk_ph2, nmi, irq_src, src_en, src_edge,
               irq_mask, poll, brk, int_ack, vec_fetch,
        output irq_out, nmi_out, int_out, int_vec, int_src, src_pending
    );
endinterface

// File: rtl/interrupt_arbiter_src_det.sv
// Per-source IRQ detector: level follow or falling-edge latch, sampled on phi2.
module int_src_det (
    input  logic sys_clock,
    input  logic rst,
    input  logic clk_ph2,
    input  logic irq_n,
    input  logic edge_mode,
    input  logic clr,
    output logic pending,
    output logic pending_kept
);
    logic lvl_q, lvl_d;
    logic pend_q, pend_d;
    logic prev_q, prev_d;

    // clear arrives on phi1, a new edge on phi2, so a re-arriving edge is never lost
    always_comb begin
        lvl_d  = lvl_q;
        pend_d = pend_q;
        prev_d = prev_q;
        if (clr) begin
            pend_d = 1'b0;
        end
        if (clk_ph2) begin
            lvl_d  = !edge_mode && !irq_n;
            prev_d = irq_n;
            if (edge_mode && prev_q && !irq_n) begin
                pend_d = 1'b1;
            end
        end
    end

    // detector state registers
    always_ff @(posedge sys_clock or posedge rst) begin
        if (rst) begin
            lvl_q  <= 1'b0;
            pend_q <= 1'b0;
            prev_q <= 1'b1;
        end else begin
            lvl_q  <= lvl_d;
            pend_q <= pend_d;
            prev_q <= prev_d;
        end
    end

    assign pending      = lvl_q | pend_q;
    assign pending_kept = lvl_q | (pend_q & !clr);

endmodule

// File: rtl/interrupt_arbiter.sv
// 6502 interrupt arbiter: NMI plus NUM_SRC prioritised IRQ sources.
// Optional build macro INT_ARB_NMI_HIJACK_EN lets a late NMI take over the vector fetch.
module interrupt_arbiter
    import int_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 3
) (
    input logic                sys_clock,
    input logic                rst,
    interrupt_arbiter_if.slave bus
);
    logic [NUM_SRC-1:0] pending, pending_kept, active, pend_clr, scan;
    logic [SRC_W-1:0]   win_src;
    logic               found;
    logic               irq_commit, nmi_commit;

    state_t             state_q, state_d;
    kind_t              kind_q, kind_d;
    logic               irq_out_q, irq_out_d;
    logic               nmi_out_q, nmi_out_d;
    logic               int_out_q, int_out_d;
    logic [15:0]        int_vec_q, int_vec_d;
    logic [SRC_W-1:0]   int_src_q, int_src_d;
    logic               nmi_pre_q, nmi_pre_d;
    logic               nmi_det_q, nmi_det_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign pend_clr[i] = irq_commit && (int_src_q == SRC_W'(i));
        int_src_det u_det (
            .sys_clock    (sys_clock),
            .rst          (rst),
            .clk_ph2      (bus.clk_ph2),
            .irq_n        (bus.irq_src[i]),
            .edge_mode    (bus.src_edge[i]),
            .clr          (pend_clr[i]),
            .pending      (pending[i]),
            .pending_kept (pending_kept[i])
        );
    end

    assign active = pending & bus.src_en;

    // priority encoder: lowest enabled pending index wins
    always_comb begin
        win_src = '0;
        found   = 1'b0;
        scan    = active;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (scan[0] && !found) begin
                win_src = SRC_W'(i);
                found   = 1'b1;
            end
            scan = scan >> 1;
        end
    end

    // sequencer FSM, advances on phi1 only
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        int_out_d  = int_out_q;
        int_src_d  = int_src_q;
        irq_commit = 1'b0;
        nmi_commit = 1'b0;
        if (bus.clk_ph1) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.poll && (irq_out_q || nmi_out_q)) begin
                        state_d   = ST_ARMED;
                        int_out_d = 1'b1;
                        kind_d    = nmi_out_q ? KIND_NMI : KIND_IRQ;
                        int_src_d = win_src;
                    end else if (bus.brk && bus.vec_fetch) begin
                        kind_d = KIND_IRQ;
`ifdef INT_ARB_NMI_HIJACK_EN
                        if (nmi_out_q) begin
                            kind_d     = KIND_NMI;
                            nmi_commit = 1'b1;
                        end
`endif
                    end
                end
                ST_ARMED: begin
                    if (bus.int_ack) begin
                        state_d   = ST_SEQ;
                        int_out_d = 1'b0;
                    end
                end
                ST_SEQ: begin
                    if (bus.vec_fetch) begin
                        state_d = ST_IDLE;
`ifdef INT_ARB_NMI_HIJACK_EN
                        if (nmi_out_q) begin
                            kind_d     = KIND_NMI;
                            nmi_commit = 1'b1;
                        end else
`endif
                        if (kind_q == KIND_NMI) begin
                            nmi_commit = 1'b1;
                        end else if (kind_q == KIND_IRQ) begin
                            irq_commit = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // request latches and NMI edge detector; commits mask out the source being cleared
    // so a serviced request does not linger one extra phase
    always_comb begin
        irq_out_d = irq_out_q;
        nmi_out_d = nmi_out_q;
        nmi_pre_d = nmi_pre_q;
        nmi_det_d = nmi_det_q;
        int_vec_d = vec_of(kind_d);
        if (bus.clk_ph1) begin
            irq_out_d = |(pending_kept & bus.src_en) && !bus.irq_mask;
            nmi_out_d = nmi_det_q && !nmi_commit;
        end
        if (nmi_commit) begin
            nmi_det_d = 1'b0;
        end
        if (bus.clk_ph2) begin
            nmi_pre_d = bus.nmi;
            if (nmi_pre_q && !bus.nmi) begin
                nmi_det_d = 1'b1;
            end
        end
    end

    // state registers; reset replays the start-up RESET sequence
    always_ff @(posedge sys_clock or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ARMED;
            kind_q    <= KIND_RESET;
            irq_out_q <= 1'b0;
            nmi_out_q <= 1'b0;
            int_out_q <= 1'b1;
            int_vec_q <= VEC_RST;
            int_src_q <= '0;
            nmi_pre_q <= 1'b1;
            nmi_det_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            irq_out_q <= irq_out_d;
            nmi_out_q <= nmi_out_d;
            int_out_q <= int_out_d;
            int_vec_q <= int_vec_d;
            int_src_q <= int_src_d;
            nmi_pre_q <= nmi_pre_d;
            nmi_det_q <= nmi_det_d;
        end
    end

    assign bus.irq_out     = irq_out_q;
    assign bus.nmi_out     = nmi_out_q;
    assign bus.int_out     = int_out_q;
    assign bus.int_vec     = int_vec_q;
    assign bus.int_src     = int_src_q;
    assign bus.src_pending = pending;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: directed scenarios plus random stimulus
// against a behavioural model of the arbitration rules.
module tb_interrupt_arbiter;
    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 3;

    logic sys_clock = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    interrupt_arbiter_if #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) bus ();

    interrupt_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) dut (
        .sys_clock (sys_clock),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 sys_clock = ~sys_clock;

    always @(posedge sys_clock) begin
        assert (!(bus.clk_ph1 && bus.clk_ph2)) else $error("phase enables overlap");
    end

    // behavioural model: kind 0=reset 1=nmi 2=irq
    bit [NUM_SRC-1:0] m_pend, m_lvl, m_prev;
    bit               m_nmi_det, m_nmi_prev, m_irq_out, m_nmi_out, m_int_out;
    int               m_kind;
    string            m_phase;
    int unsigned      m_src;

    function automatic int unsigned vec_for(input int k);
        if (k == 1) return 32'hFFFA;
        if (k == 2) return 32'hFFFE;
        return 32'hFFFC;
    endfunction

    function automatic int unsigned lowest(input bit [NUM_SRC-1:0] v);
        for (int i = 0; i < NUM_SRC; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_lvl = '0; m_prev = '1;
        m_nmi_det = 0; m_nmi_prev = 1; m_irq_out = 0; m_nmi_out = 0; m_int_out = 1;
        m_kind = 0; m_phase = "armed"; m_src = 0;
    endtask

    task automatic model_edge();
        bit [NUM_SRC-1:0] clr;
        bit nclr;
        clr = '0;
        nclr = 0;
        if (bus.clk_ph1) begin
            if (m_phase == "idle") begin
                if (bus.poll && (m_irq_out || m_nmi_out)) begin
                    m_phase = "armed";
                    m_int_out = 1;
                    m_kind = m_nmi_out ? 1 : 2;
                    m_src = lowest((m_lvl | m_pend) & bus.src_en);
                end else if (bus.brk && bus.vec_fetch) begin
                    m_kind = 2;
`ifdef INT_ARB_NMI_HIJACK_EN
                    if (m_nmi_out) begin m_kind = 1; nclr = 1; end
`endif
                end
            end else if (m_phase == "armed") begin
                if (bus.int_ack) begin m_phase = "seq"; m_int_out = 0; end
            end else if (bus.vec_fetch) begin
                m_phase = "idle";
`ifdef INT_ARB_NMI_HIJACK_EN
                if (m_nmi_out) m_kind = 1;
`endif
                if (m_kind == 1) nclr = 1;
                else if (m_kind == 2) clr[m_src] = 1;
            end
            m_irq_out = ((((m_pend & ~clr) | m_lvl) & bus.src_en) != 0) && !bus.irq_mask;
            m_nmi_out = m_nmi_det && !nclr;
            m_pend &= ~clr;
            if (nclr) m_nmi_det = 0;
        end
        if (bus.clk_ph2) begin
            m_pend |= bus.src_edge & m_prev & ~bus.irq_src;
            m_lvl = ~bus.src_edge & ~bus.irq_src;
            m_prev = bus.irq_src;
            if (m_nmi_prev && !bus.nmi) m_nmi_det = 1;
            m_nmi_prev = bus.nmi;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("irq_out", 32'(bus.irq_out), 32'(m_irq_out));
        check("nmi_out", 32'(bus.nmi_out), 32'(m_nmi_out));
        check("int_out", 32'(bus.int_out), 32'(m_int_out));
        check("int_vec", 32'(bus.int_vec), vec_for(m_kind));
        check("int_src", 32'(bus.int_src), m_src);
        check("src_pending", 32'(bus.src_pending), 32'(m_lvl | m_pend));
    endtask

    task automatic step(input bit p1, input bit p2);
        @(negedge sys_clock);
        bus.clk_ph1 = p1;
        bus.clk_ph2 = p2;
        @(posedge sys_clock);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic finish_seq();
        bus.poll = 0; bus.int_ack = 1;
        step(1, 0);
        bus.int_ack = 0; bus.vec_fetch = 1;
        step(1, 0);
        bus.vec_fetch = 0;
    endtask

    initial begin
        rst = 1;
        bus.clk_ph1 = 0; bus.clk_ph2 = 0; bus.nmi = 1; bus.irq_src = '1;
        bus.src_en = '0; bus.src_edge = '0; bus.irq_mask = 1; bus.poll = 0;
        bus.brk = 0; bus.int_ack = 0; bus.vec_fetch = 0;
        model_reset();
        repeat (3) @(negedge sys_clock);
        rst = 0;
        #1;
        check("rst_int_out", 32'(bus.int_out), 32'd1);
        check("rst_int_vec", 32'(bus.int_vec), 32'hFFFC);
        check("rst_pending", 32'(bus.src_pending), 32'd0);

        // boot sequence completes into IDLE
        finish_seq();
        check("boot_idle_int_out", 32'(bus.int_out), 32'd0);

        // level source 1
        bus.src_en = 4'b0010; bus.src_edge = 4'b0000; bus.irq_mask = 0; bus.irq_src = 4'b1101;
        step(0, 1);
        step(1, 0);
        check("lvl_irq_out", 32'(bus.irq_out), 32'd1);
        bus.poll = 1;
        step(1, 0);
        check("lvl_int_out", 32'(bus.int_out), 32'd1);
        check("lvl_int_src", 32'(bus.int_src), 32'd1);
        check("lvl_int_vec", 32'(bus.int_vec), 32'hFFFE);
        finish_seq();
        bus.irq_src = '1;
        step(0, 1);
        step(1, 0);

        // simultaneous edges on sources 0 and 2
        bus.src_edge = 4'b0101; bus.src_en = 4'b0101; bus.irq_src = 4'b1010;
        step(0, 1);
        check("edge_pending", 32'(bus.src_pending), 32'b0101);
        step(1, 0);
        bus.poll = 1;
        step(1, 0);
        check("edge_win0", 32'(bus.int_src), 32'd0);
        finish_seq();
        check("edge_after_clr", 32'(bus.src_pending), 32'b0100);
        bus.poll = 1;
        step(1, 0);
        check("edge_win2", 32'(bus.int_src), 32'd2);
        finish_seq();
        check("edge_all_clr", 32'(bus.src_pending), 32'd0);
        bus.irq_src = '1;
        step(0, 1);

        // NMI with IRQs masked, held low afterwards
        bus.irq_mask = 1; bus.src_en = '0; bus.nmi = 0;
        step(0, 1);
        step(1, 0);
        check("nmi_out", 32'(bus.nmi_out), 32'd1);
        bus.poll = 1;
        step(1, 0);
        check("nmi_vec", 32'(bus.int_vec), 32'hFFFA);
        finish_seq();
        bus.poll = 1;
        repeat (2) begin step(0, 1); step(1, 0); end
        check("nmi_single", 32'(bus.int_out), 32'd0);
        bus.poll = 0; bus.nmi = 1;
        step(0, 1);

        // BRK with an NMI arriving after BRK started
        bus.brk = 1; bus.nmi = 0;
        step(0, 1);
        step(1, 0);
        bus.vec_fetch = 1;
        step(1, 0);
`ifdef INT_ARB_NMI_HIJACK_EN
        check("brk_vec", 32'(bus.int_vec), 32'hFFFA);
        check("brk_nmi_out", 32'(bus.nmi_out), 32'd0);
`else
        check("brk_vec", 32'(bus.int_vec), 32'hFFFE);
        check("brk_nmi_out", 32'(bus.nmi_out), 32'd1);
`endif
        bus.vec_fetch = 0; bus.brk = 0; bus.poll = 1;
        step(1, 0);
`ifdef INT_ARB_NMI_HIJACK_EN
        check("brk_late_nmi", 32'(bus.int_out), 32'd0);
`else
        check("brk_late_nmi", 32'(bus.int_vec), 32'hFFFA);
`endif
        finish_seq();
        bus.nmi = 1;
        step(0, 1);

        // asynchronous reset while in SEQ
        bus.src_en = 4'b0001; bus.src_edge = 4'b0001; bus.irq_mask = 0; bus.irq_src = 4'b1110;
        step(0, 1);
        step(1, 0);
        bus.poll = 1;
        step(1, 0);
        bus.poll = 0; bus.int_ack = 1;
        step(1, 0);
        bus.int_ack = 0;
        #1 rst = 1;
        #1;
        model_reset();
        check("arst_int_out", 32'(bus.int_out), 32'd1);
        check("arst_int_vec", 32'(bus.int_vec), 32'hFFFC);
        check("arst_pending", 32'(bus.src_pending), 32'd0);
        bus.irq_src = '1;
        @(negedge sys_clock);
        rst = 0;

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            int ph;
            if ($urandom_range(0, 15) == 0) bus.nmi = ~bus.nmi;
            for (int i = 0; i < NUM_SRC; i++)
                if ($urandom_range(0, 7) == 0) bus.irq_src[i] = ~bus.irq_src[i];
            if ($urandom_range(0, 31) == 0) bus.src_en = 4'($urandom);
            if ($urandom_range(0, 63) == 0) bus.src_edge = 4'($urandom);
            if ($urandom_range(0, 3) == 0) bus.irq_mask = ~bus.irq_mask;
            bus.poll = ($urandom_range(0, 2) == 0);
            bus.brk = ($urandom_range(0, 7) == 0);
            bus.int_ack = ($urandom_range(0, 3) == 0);
            bus.vec_fetch = ($urandom_range(0, 3) == 0);
            ph = $urandom_range(0, 2);
            step(ph == 1, ph == 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
